// File: rtl/fifo_64i_16o_unpack_pkg.sv
// Shared widths, ratio/log2 helpers and the handshake-fire rule for the 64->16 unpacker
// and its packing counterpart.
package fifo_64i_16o_unpack_pkg;

    localparam int DEF_IN_WIDTH  = 64;
    localparam int DEF_OUT_WIDTH = 16;

    function automatic int ratio_f(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Never returns 0 so a RATIO of 1 still yields a legal 1-bit beat index.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic hs_fire(input logic en, input logic vld);
        return en && vld;
    endfunction

endpackage

// File: rtl/fifo_64i_16o_unpack_if.sv
// Write/read handshake bundle of the unpacker: enable from the user, valid from the block.
interface fifo_64i_16o_unpack_if
    import fifo_64i_16o_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
    logic                 wr_en;
    logic                 wr_vld;
    logic [IN_WIDTH-1:0]  wr_data;
    logic                 rd_en;
    logic                 rd_vld;
    logic [OUT_WIDTH-1:0] rd_data;
    logic                 rd_last;
    logic [1:0]           word_cnt;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_vld, rd_vld, rd_data, rd_last, word_cnt
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_vld, rd_vld, rd_data, rd_last, word_cnt
    );
endinterface

// File: rtl/fifo_64i_16o_unpack_mux.sv
// Beat selector: picks slice beat_idx of the head word, beat 0 = least-significant.
// Purely combinational, no backpressure.
module fifo_64i_16o_unpack_mux
    import fifo_64i_16o_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int BEAT_W    = clog2_f(ratio_f(DEF_IN_WIDTH, DEF_OUT_WIDTH))
) (
    input  logic [IN_WIDTH-1:0]  head_word,
    input  logic [BEAT_W-1:0]    beat_idx,
    output logic [OUT_WIDTH-1:0] beat_data
);
    localparam int RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);

    always_comb begin
        beat_data = head_word[OUT_WIDTH-1:0];
        for (int i = 1; i < RATIO; i++) begin
            if (beat_idx == BEAT_W'(i)) begin
                beat_data = head_word[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/fifo_64i_16o_unpack.sv
// 2-word buffer emitting each 64-bit word as four 16-bit beats, LSB first; first-word-fall-through.
// Latency 1 edge write-to-beat-0; wr_vld drops at 2 words and comes only from registered count.
module fifo_64i_16o_unpack
    import fifo_64i_16o_unpack_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_64i_16o_unpack_if.slave bus
);
    localparam int                RATIO     = ratio_f(IN_WIDTH, OUT_WIDTH);
    localparam int                BEAT_W    = clog2_f(RATIO);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    logic [IN_WIDTH-1:0]  mem_q [2];
    logic [IN_WIDTH-1:0]  mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [BEAT_W-1:0]    beat_idx_q, beat_idx_d;
    logic                 wr_vld, rd_vld;
    logic                 wr_fire, rd_fire, word_done;
    logic [OUT_WIDTH-1:0] rd_data;

    assign wr_vld = (cnt_q != 2'd2);
    assign rd_vld = (cnt_q != 2'd0);

    always_comb begin
        wr_fire    = hs_fire(bus.wr_en, wr_vld);
        rd_fire    = hs_fire(bus.rd_en, rd_vld);
        word_done  = rd_fire && (beat_idx_q == LAST_BEAT);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        beat_idx_d = beat_idx_q;

        if (wr_fire) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd_fire) begin
            beat_idx_d = word_done ? '0 : beat_idx_q + BEAT_W'(1);
        end
        if (word_done) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // A write landing on the same edge as a word retiring leaves the count unchanged.
        case ({wr_fire, word_done})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            beat_idx_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    // Word storage is data-only and deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    fifo_64i_16o_unpack_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .BEAT_W    (BEAT_W)
    ) u_mux (
        .head_word (mem_q[rd_ptr_q]),
        .beat_idx  (beat_idx_q),
        .beat_data (rd_data)
    );

    assign bus.wr_vld   = wr_vld;
    assign bus.rd_vld   = rd_vld;
    assign bus.rd_data  = rd_data;
    assign bus.rd_last  = rd_vld && (beat_idx_q == LAST_BEAT);
    assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_64i_16o_unpack.sv
// Bench for the 64->16 unpacker: queue-based word model compared every cycle, plus directed literal checks.
module tb_fifo_64i_16o_unpack;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_64i_16o_unpack_if bus ();

    fifo_64i_16o_unpack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of whole words plus the index of the beat on show.
    logic [63:0] mq[$];
    int          mbeat = 0;

    always @(posedge clk) begin
        logic acc;
        if (rst) begin
            mq.delete();
            mbeat = 0;
        end else begin
            acc = bus.wr_en && (mq.size() < 2);
            if (bus.rd_en && mq.size() > 0) begin
                if (mbeat == 3) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                end else begin
                    mbeat++;
                end
            end
            if (acc) mq.push_back(bus.wr_data);
        end
    end

    always @(negedge clk) begin
        logic [63:0] sh;
        if (chk_en) begin
            lit("m_word_cnt", 64'(bus.word_cnt), 64'(mq.size()));
            lit("m_wr_vld", 64'(bus.wr_vld), 64'(mq.size() < 2));
            lit("m_rd_vld", 64'(bus.rd_vld), 64'(mq.size() != 0));
            lit("m_rd_last", 64'(bus.rd_last), 64'(mq.size() != 0 && mbeat == 3));
            if (mq.size() != 0) begin
                sh = mq[0] >> (mbeat * 16);
                lit("m_rd_data", 64'(bus.rd_data), 64'(sh[15:0]));
            end
        end
    end

    task automatic tick(input logic r, input logic we, input logic [63:0] wd, input logic re);
        rst         = r;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(negedge clk);
    endtask

    function automatic logic [15:0] beat_of(input logic [63:0] w, input int i);
        logic [63:0] s;
        s = w >> (i * 16);
        return s[15:0];
    endfunction

    initial begin
        logic [63:0] wa, wb, wc, wd_drop;
        logic [15:0] got[$];
        logic        seen;
        int          gaps;

        tick(1, 0, 64'd0, 0);
        tick(1, 0, 64'd0, 0);
        chk_en = 1'b1;
        tick(0, 0, 64'd0, 0);
        lit("rst_wr_vld", 64'(bus.wr_vld), 64'd1);
        lit("rst_rd_vld", 64'(bus.rd_vld), 64'd0);
        lit("rst_rd_last", 64'(bus.rd_last), 64'd0);
        lit("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, 64'd0, 1);
        lit("idle_word_cnt", 64'(bus.word_cnt), 64'd0);
        lit("idle_rd_vld", 64'(bus.rd_vld), 64'd0);

        // Single word, then continuous read.
        tick(0, 1, 64'h4444_3333_2222_1111, 0);
        lit("single_b0", 64'(bus.rd_data), 64'h1111);
        lit("single_cnt", 64'(bus.word_cnt), 64'd1);
        tick(0, 0, 64'd0, 1);
        lit("single_b1", 64'(bus.rd_data), 64'h2222);
        lit("single_last1", 64'(bus.rd_last), 64'd0);
        tick(0, 0, 64'd0, 1);
        lit("single_b2", 64'(bus.rd_data), 64'h3333);
        tick(0, 0, 64'd0, 1);
        lit("single_b3", 64'(bus.rd_data), 64'h4444);
        lit("single_last3", 64'(bus.rd_last), 64'd1);
        tick(0, 0, 64'd0, 1);
        lit("single_empty", 64'(bus.rd_vld), 64'd0);

        // Fill to full, third write dropped.
        wa      = 64'hA003_A002_A001_A000;
        wb      = 64'hB003_B002_B001_B000;
        wc      = 64'hC003_C002_C001_C000;
        wd_drop = 64'hDDDD_DDDD_DDDD_DDDD;
        tick(0, 1, wa, 0);
        tick(0, 1, wb, 0);
        lit("full_cnt", 64'(bus.word_cnt), 64'd2);
        lit("full_wr_vld", 64'(bus.wr_vld), 64'd0);
        tick(0, 1, wd_drop, 0);
        lit("drop_cnt", 64'(bus.word_cnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            lit("full_order", 64'(bus.rd_data), 64'(beat_of((i < 4) ? wa : wb, i % 4)));
            tick(0, 0, 64'd0, 1);
        end
        lit("full_drained", 64'(bus.rd_vld), 64'd0);

        // Full with last-beat read: write refused that cycle, wr_vld back next cycle.
        tick(0, 1, wa, 0);
        tick(0, 1, wb, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 64'd0, 1);
        lit("fl_last", 64'(bus.rd_last), 64'd1);
        lit("fl_wr_vld0", 64'(bus.wr_vld), 64'd0);
        tick(0, 1, wd_drop, 1);
        lit("fl_wr_vld1", 64'(bus.wr_vld), 64'd1);
        lit("fl_cnt", 64'(bus.word_cnt), 64'd1);
        lit("fl_b_beat0", 64'(bus.rd_data), 64'hB000);
        for (int i = 0; i < 3; i++) tick(0, 0, 64'd0, 1);
        tick(0, 1, wc, 1);
        lit("simul_cnt", 64'(bus.word_cnt), 64'd1);
        lit("simul_c_beat0", 64'(bus.rd_data), 64'hC000);
        for (int i = 0; i < 4; i++) tick(0, 0, 64'd0, 1);
        lit("simul_empty", 64'(bus.rd_vld), 64'd0);

        // Streaming: one word per 4 cycles, reader always enabled.
        seen = 1'b0;
        gaps = 0;
        for (int c = 0; c < 36; c++) begin
            if (bus.rd_vld) begin
                got.push_back(bus.rd_data);
                seen = 1'b1;
            end else if (seen && got.size() < 32) begin
                gaps++;
            end
            tick(0, (c % 4 == 0) && (c / 4 < 8), {4{16'(c / 4)}}, 1);
        end
        lit("stream_beats", 64'(got.size()), 64'd32);
        lit("stream_gaps", 64'(gaps), 64'd0);
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            lit("stream_data", 64'(got[i]), 64'(i / 4));
        end

        // Reset mid-word.
        tick(0, 1, 64'h1234_5678_9ABC_DEF0, 0);
        tick(0, 0, 64'd0, 1);
        tick(0, 0, 64'd0, 1);
        lit("mid_b2", 64'(bus.rd_data), 64'h5678);
        tick(1, 0, 64'd0, 0);
        lit("mid_rst_vld", 64'(bus.rd_vld), 64'd0);
        lit("mid_rst_cnt", 64'(bus.word_cnt), 64'd0);
        tick(0, 1, 64'h0F0F_0E0E_0D0D_0C0C, 0);
        lit("mid_new_b0", 64'(bus.rd_data), 64'h0C0C);
        for (int i = 0; i < 4; i++) tick(0, 0, 64'd0, 1);

        // Randomized traffic with occasional resets and varying read pressure.
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 149) == 0,
                 $urandom_range(0, 1) == 1,
                 {$urandom, $urandom},
                 $urandom_range(0, 3) < ((c < 1500) ? 3 : 1));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
